// File: rtl/instr_encoder_loader_if.sv
// Symbolic instruction field stream feeding instr_encoder_loader.
// master drives the fields, slave (the encoder) returns in_ready.
interface instr_encoder_loader_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_last;
    logic [4:0] in_opcode;
    logic [3:0] in_dst;
    logic [3:0] in_src1;
    logic [3:0] in_src0;
    logic [7:0] in_imm;

    modport master (
        output in_valid, in_last, in_opcode, in_dst, in_src1, in_src0, in_imm,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_last, in_opcode, in_dst, in_src1, in_src0, in_imm,
        output in_ready
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Packs symbolic instruction fields into 16-bit words and writes them sequentially to imem.
// Optional macro ENC_FIELD_CHECK_EN adds a sticky err_field flag for truncated fields.
module instr_encoder_loader #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    instr_encoder_loader_if.slave instr,
    output logic                  imem_we,
    output logic [ADDR_W-1:0]     imem_addr,
    output logic [15:0]           imem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W:0]       count,
    output logic                  err_illegal,
    output logic                  err_overflow
`ifdef ENC_FIELD_CHECK_EN
    ,
    output logic                  err_field
`endif
);

    localparam logic [4:0] OP_JMP           = 5'd0;
    localparam logic [4:0] OP_JNZ           = 5'd1;
    localparam logic [4:0] OP_INC           = 5'd2;
    localparam logic [4:0] OP_INC_DEPTH     = 5'd3;
    localparam logic [4:0] OP_COPY          = 5'd4;
    localparam logic [4:0] OP_REFERENCE     = 5'd5;
    localparam logic [4:0] OP_TO_UP         = 5'd6;
    localparam logic [4:0] OP_TO_DOWN       = 5'd7;
    localparam logic [4:0] OP_TO_RIGHT      = 5'd8;
    localparam logic [4:0] OP_TO_LEFT       = 5'd9;
    localparam logic [4:0] OP_WHERE_ZERO    = 5'd10;
    localparam logic [4:0] OP_INIT_DEPTH    = 5'd11;
    localparam logic [4:0] OP_COMP          = 5'd12;
    localparam logic [4:0] OP_CHECK         = 5'd13;
    localparam logic [4:0] OP_CHECK_4       = 5'd14;
    localparam logic [4:0] OP_POSSIBLE_UP   = 5'd15;
    localparam logic [4:0] OP_POSSIBLE_DOWN = 5'd16;
    localparam logic [4:0] OP_POSSIBLE_RIGHT= 5'd17;
    localparam logic [4:0] OP_POSSIBLE_LEFT = 5'd18;
    localparam logic [4:0] OP_STORE         = 5'd19;
    localparam logic [4:0] OP_LI            = 5'd20;

    localparam logic [ADDR_W:0] FULL = DEPTH[ADDR_W:0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE_LAST,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic              accept;
    logic              legal;
    logic [15:0]       enc;
    logic [ADDR_W-1:0] wr_ptr;
    logic              we_q;
`ifdef ENC_FIELD_CHECK_EN
    logic              trunc;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        instr.in_ready = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        accept         = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                instr.in_ready = 1'b1;
                busy           = 1'b1;
                if (instr.in_valid) begin
                    accept = 1'b1;
                    if (count == FULL)      state_nxt = S_DONE;
                    else if (instr.in_last) state_nxt = S_WRITE_LAST;
                end
            end
            S_WRITE_LAST: begin
                busy      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        enc        = '0;
        enc[15:11] = instr.in_opcode;
        legal      = 1'b1;
        case (instr.in_opcode)
            OP_JMP, OP_JNZ:
                enc[7:0] = instr.in_imm;
            OP_INC, OP_INC_DEPTH, OP_COPY, OP_REFERENCE,
            OP_TO_UP, OP_TO_DOWN, OP_TO_RIGHT, OP_TO_LEFT,
            OP_WHERE_ZERO, OP_INIT_DEPTH: begin
                enc[10:7] = instr.in_dst;
                enc[6:3]  = instr.in_src1;
            end
            OP_COMP: begin
                enc[7:4] = instr.in_src1;
                enc[3:0] = instr.in_src0;
            end
            OP_CHECK: begin
                enc[5:2] = instr.in_src1;
                enc[1:0] = instr.in_imm[1:0];
            end
            OP_CHECK_4: begin
                enc[10:7] = instr.in_src1;
                enc[6:3]  = instr.in_imm[3:0];
            end
            OP_POSSIBLE_UP, OP_POSSIBLE_DOWN, OP_POSSIBLE_RIGHT, OP_POSSIBLE_LEFT:
                enc[3:0] = instr.in_src0;
            OP_STORE: begin
                enc[10:7] = instr.in_src1;
                enc[6:3]  = instr.in_src0;
            end
            OP_LI: begin
                enc[10:7] = instr.in_dst;
                enc[6:0]  = instr.in_imm[6:0];
            end
            default: legal = 1'b0;
        endcase
    end

`ifdef ENC_FIELD_CHECK_EN
    always_comb begin
        trunc = 1'b0;
        case (instr.in_opcode)
            OP_LI:      trunc = instr.in_imm[7];
            OP_CHECK:   trunc = |instr.in_imm[7:2];
            OP_CHECK_4: trunc = |instr.in_imm[7:4];
            default:    trunc = 1'b0;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            count        <= '0;
            we_q         <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            err_illegal  <= 1'b0;
            err_overflow <= 1'b0;
`ifdef ENC_FIELD_CHECK_EN
            err_field    <= 1'b0;
`endif
        end else begin
            we_q <= 1'b0;
            if (state == S_IDLE && start) begin
                wr_ptr       <= base_addr;
                count        <= '0;
                err_illegal  <= 1'b0;
                err_overflow <= 1'b0;
`ifdef ENC_FIELD_CHECK_EN
                err_field    <= 1'b0;
`endif
            end
            if (accept) begin
                if (count == FULL) begin
                    err_overflow <= 1'b1;
                end else if (!legal) begin
                    err_illegal <= 1'b1;
                end else begin
                    we_q       <= 1'b1;
                    imem_addr  <= wr_ptr;
                    imem_wdata <= enc;
                    wr_ptr     <= wr_ptr + 1'b1;
                    count      <= count + 1'b1;
`ifdef ENC_FIELD_CHECK_EN
                    if (trunc) err_field <= 1'b1;
`endif
                end
            end
        end
    end

    // Strobe is masked by rst so a write registered just before reset never reaches imem.
    assign imem_we = we_q & ~rst;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed self-checking bench for instr_encoder_loader with hand-computed instruction words.
// Build with ENC_FIELD_CHECK_EN defined to also exercise err_field.
module tb_instr_encoder_loader;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    localparam logic [4:0] JMP   = 5'd0;
    localparam logic [4:0] INC   = 5'd2;
    localparam logic [4:0] COMP  = 5'd12;
    localparam logic [4:0] CHECK = 5'd13;
    localparam logic [4:0] STORE = 5'd19;
    localparam logic [4:0] LI    = 5'd20;
    localparam logic [4:0] BAD   = 5'h1F;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   count;
    logic              err_illegal;
    logic              err_overflow;
`ifdef ENC_FIELD_CHECK_EN
    logic              err_field;
`endif

    instr_encoder_loader_if instr ();

    instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .instr        (instr.slave),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .busy         (busy),
        .done         (done),
        .count        (count),
        .err_illegal  (err_illegal),
        .err_overflow (err_overflow)
`ifdef ENC_FIELD_CHECK_EN
        ,
        .err_field    (err_field)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned done_cnt = 0;
    logic [ADDR_W-1:0] wa_q[$];
    logic [15:0]       wd_q[$];

    always @(negedge clk) begin
        if (imem_we) begin
            wa_q.push_back(imem_addr);
            wd_q.push_back(imem_wdata);
        end
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] base);
        start     = 1'b1;
        base_addr = base;
        tick();
        start     = 1'b0;
    endtask

    task automatic send(input logic [4:0] op, input logic [3:0] dst, input logic [3:0] s1,
                        input logic [3:0] s0, input logic [7:0] imm, input logic last);
        bit ok = 1'b0;
        instr.in_valid  = 1'b1;
        instr.in_opcode = op;
        instr.in_dst    = dst;
        instr.in_src1   = s1;
        instr.in_src0   = s0;
        instr.in_imm    = imm;
        instr.in_last   = last;
        for (int i = 0; i < 20; i++) begin
            if (instr.in_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        instr.in_valid = 1'b0;
        instr.in_last  = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        tick();
        tick();
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
    endtask

    int unsigned d0;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        instr.in_valid = 1'b0;
        instr.in_last = 1'b0;
        instr.in_opcode = '0;
        instr.in_dst = '0;
        instr.in_src1 = '0;
        instr.in_src0 = '0;
        instr.in_imm = '0;
        repeat (3) tick();

        check("rst_in_ready", instr.in_ready, 0);
        check("rst_we", imem_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_count", count, 0);
        check("rst_errs", {err_illegal, err_overflow}, 0);
        rst = 1'b0;
        tick();

        // single LI with last
        clear_log();
        d0 = done_cnt;
        pulse_start(6'd0);
        check("t1_busy", busy, 1);
        send(LI, 4'd3, 4'd0, 4'd0, 8'h55, 1'b1);
        check("t1_we", imem_we, 1);
        check("t1_addr", imem_addr, 0);
        check("t1_wdata", imem_wdata, 16'hA1D5);
        check("t1_ready_wl", instr.in_ready, 0);
        wait_done();
        check("t1_done_pulses", done_cnt - d0, 1);
        check("t1_count", count, 1);
        check("t1_busy_idle", busy, 0);
        check("t1_nwrites", wa_q.size(), 1);

        // five back-to-back accepts
        clear_log();
        pulse_start(6'd0);
        send(INC,   4'd1, 4'd2, 4'd0, 8'h00, 1'b0);
        send(COMP,  4'd0, 4'd4, 4'd5, 8'h00, 1'b0);
        send(CHECK, 4'd0, 4'd6, 4'd0, 8'h02, 1'b0);
        send(STORE, 4'd0, 4'd7, 4'd8, 8'h00, 1'b0);
        send(JMP,   4'd0, 4'd0, 4'd0, 8'h2A, 1'b1);
        wait_done();
        check("t2_nwrites", wa_q.size(), 5);
        if (wa_q.size() == 5) begin
            check("t2_a0", wa_q[0], 0); check("t2_d0", wd_q[0], 16'h1090);
            check("t2_a1", wa_q[1], 1); check("t2_d1", wd_q[1], 16'h6045);
            check("t2_a2", wa_q[2], 2); check("t2_d2", wd_q[2], 16'h681A);
            check("t2_a3", wa_q[3], 3); check("t2_d3", wd_q[3], 16'h9BC0);
            check("t2_a4", wa_q[4], 4); check("t2_d4", wd_q[4], 16'h002A);
        end
        check("t2_count", count, 5);

        // illegal opcode between two INCs; start mid-session must be ignored
        clear_log();
        pulse_start(6'd0);
        send(INC, 4'd1, 4'd2, 4'd0, 8'h00, 1'b0);
        pulse_start(6'd30);
        check("t3_busy_ign", busy, 1);
        check("t3_count_ign", count, 1);
        send(BAD, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0);
        send(INC, 4'd3, 4'd4, 4'd0, 8'h00, 1'b1);
        wait_done();
        check("t3_nwrites", wa_q.size(), 2);
        if (wa_q.size() == 2) begin
            check("t3_a0", wa_q[0], 0); check("t3_d0", wd_q[0], 16'h1090);
            check("t3_a1", wa_q[1], 1); check("t3_d1", wd_q[1], 16'h11A0);
        end
        check("t3_err_illegal", err_illegal, 1);
        check("t3_count", count, 2);

        // wrap from base 60 and overflow on the 65th accept
        clear_log();
        d0 = done_cnt;
        pulse_start(6'd60);
        check("t4_err_illegal_clr", err_illegal, 0);
        for (int i = 0; i < 65; i++) begin
            logic [7:0] v;
            v = 8'(i);
            send(JMP, 4'd0, 4'd0, 4'd0, v, i == 64);
        end
        wait_done();
        check("t4_nwrites", wa_q.size(), 64);
        if (wa_q.size() == 64) begin
            check("t4_a0", wa_q[0], 60);  check("t4_d0", wd_q[0], 16'h0000);
            check("t4_a3", wa_q[3], 63);  check("t4_d3", wd_q[3], 16'h0003);
            check("t4_a4", wa_q[4], 0);   check("t4_d4", wd_q[4], 16'h0004);
            check("t4_a63", wa_q[63], 59); check("t4_d63", wd_q[63], 16'h003F);
        end
        check("t4_err_overflow", err_overflow, 1);
        check("t4_count", count, 64);
        check("t4_done_pulses", done_cnt - d0, 1);

        // reset the cycle after an accept
        clear_log();
        pulse_start(6'd0);
        check("t5_ovf_clr", err_overflow, 0);
        send(INC, 4'd1, 4'd2, 4'd0, 8'h00, 1'b0);
        check("t5_count_pre", count, 1);
        rst = 1'b1;
        #1;
        check("t5_we_masked", imem_we, 0);
        tick();
        rst = 1'b0;
        check("t5_busy", busy, 0);
        check("t5_count", count, 0);
        check("t5_ready", instr.in_ready, 0);
        tick();
        check("t5_nwrites", wa_q.size(), 0);

        // LI with imm[7] set: truncated word still written
        clear_log();
        pulse_start(6'd0);
        send(LI, 4'd0, 4'd0, 4'd0, 8'h80, 1'b1);
        wait_done();
        check("t6_nwrites", wa_q.size(), 1);
        if (wa_q.size() == 1) check("t6_wdata", wd_q[0], 16'hA000);
`ifdef ENC_FIELD_CHECK_EN
        check("t6_err_field", err_field, 1);
`endif
        check("t6_err_illegal", err_illegal, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Opposite end of the instruction decoder for the 8-puzzle solver core.
- Accepts symbolic instruction fields over a valid/ready stream and packs each one into the 16-bit instruction format the decoder consumes.
- Writes each packed word sequentially into instruction memory, which has a 6-bit PC space.
- Used by the boot/host side to download a search program before the core is released from reset.

Parameters:
- ADDR_W, 6: instruction memory address width; must match pc_in width.
- DEPTH, 64: number of instruction words; must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load session at base_addr.
- base_addr  in  ADDR_W  first write address of the session.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  encoder can accept fields this cycle.
- in_last  in  1  marks the final instruction of the program.
- in_opcode  in  5  opcode, using the def.h constants shared with the decoder.
- in_dst  in  4  destination register.
- in_src1  in  4  source register 1.
- in_src0  in  4  source register 0.
- in_imm  in  8  immediate / jump target / check pattern.
- imem_we  out  1  instruction memory write strobe.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  16  packed instruction.
- busy  out  1  session active.
- done  out  1  one-cycle pulse when the session completes.
- count  out  ADDR_W+1  words written in the current session.
- err_illegal  out  1  sticky; an unknown opcode was dropped.
- err_overflow  out  1  sticky; a write past address DEPTH-1 was attempted.

Behaviour:
- Reset: state IDLE.
  - Outputs in_ready, imem_we, busy, done, err_illegal, err_overflow all 0.
  - imem_addr, imem_wdata and count all 0.
- States: IDLE, LOAD, WRITE_LAST, DONE.
- IDLE:
  - in_ready=0.
  - On start: wr_ptr<=base_addr, count<=0, errors cleared, go to LOAD.
- LOAD:
  - in_ready=1, busy=1.
  - Accept when in_valid & in_ready. The word is encoded and registered; imem_we=1 with the registered addr/data on the following cycle (latency 1).
  - The write pipeline allows back-to-back accepts at 1 word/cycle.
- Encoding: bits [15:11] = opcode; unused bits are 0.
  - JMP, JNZ: [7:0] = imm.
  - INC, INC_DEPTH, COPY, REFERENCE, TO_UP/DOWN/RIGHT/LEFT, WHERE_ZERO, INIT_DEPTH: [10:7] = dst, [6:3] = src1.
  - COMP: [7:4] = src1, [3:0] = src0.
  - CHECK: [5:2] = src1, [1:0] = imm[1:0].
  - CHECK_4: [10:7] = src1, [6:3] = imm[3:0].
  - POSSIBLE_UP/DOWN/RIGHT/LEFT: [3:0] = src0.
  - STORE: [10:7] = src1, [6:3] = src0.
  - LI: [10:7] = dst, [6:0] = imm[6:0].
- Illegal opcode:
  - The handshake completes, but there is no write and no pointer/count advance.
  - err_illegal is set.
  - If in_last is also set, the session still ends.
- Pointer and count: both advance on each legal accept.
- Accept with in_last:
  - The last word is written in the following cycle.
  - State goes to WRITE_LAST with in_ready=0, then to DONE.
- Overflow: an accept when count==DEPTH is dropped, err_overflow is set, and the state goes to DONE immediately. wr_ptr does not wrap.
- base_addr>0: the pointer wraps from DEPTH-1 to 0. Overflow is detected only by count.
- DONE: done=1 for one cycle, busy=0, then IDLE. Errors and count hold until the next start.
- start while busy: ignored.
- rst mid-session: any pending write is discarded (imem_we=0 in the next cycle) and all outputs return to reset values.

Optional Feature:
- Macro ENC_FIELD_CHECK_EN.
- When defined, an extra sticky output err_field (1 bit, reset 0) is present. It is set when an accepted legal instruction carries field bits that would be truncated:
  - LI with imm[7]=1.
  - CHECK with imm[7:2]!=0.
  - CHECK_4 with imm[7:4]!=0.
- The word is still written, truncated.
- When not defined, the port and logic are absent and truncation is silent.

Test Plan:
- start, base 0; single LI dst=3 imm=0x55 with in_last → imem_we one cycle later, addr 0, wdata={LI,4'd3,7'h55}; then done pulse; count=1.
- 5 back-to-back accepts (INC d=1 s=2, COMP s1=4 s0=5, CHECK s1=6 imm=2, STORE s1=7 s0=8, JMP imm=0x2A) → consecutive writes at addrs 0..4, each matching its field map; count=5.
- Opcode 5'h1F (unused) between two INCs → no write for it, addresses 0 and 1 used, err_illegal=1 after done.
- base_addr 60, 65 instructions streamed → writes at 60..63 then 0..59; the 65th accept sets err_overflow=1; done pulse; count=64.
- rst asserted the cycle after an accept → no imem_we, busy=0, count=0.
- ENC_FIELD_CHECK_EN defined: LI imm=0x80 → wdata[6:0]=0, err_field=1; undefined: same word written, no flag.
